// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_pkg
//  Description : Shared types and default fixed-point format constants for
//                the neuron multiply-accumulate datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

    // Default signed fixed-point format (Q4.27 in a 32-bit word)
    localparam int c_data_w = 32;
    localparam int c_frac_w = 27;

    // Activation applied to the final result
    typedef enum logic {
        RELU = 1'b0,
        NONE = 1'b1
    } act_mode_t;

    // Inference sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ACCUM  = 3'd2,
        DRAIN  = 3'd3,
        OUTPUT = 3'd4
    } state_t;

    // Address width for a memory of the given depth (at least one bit)
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/weight_ram.sv
`default_nettype none
// ============================================================================
//  Module      : weight_ram
//  Description : Simple dual-port weight memory, one write port and one
//                registered read port (1-cycle latency). Contents are not
//                reset so the array maps onto block RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module weight_ram
    import nn_pkg::*;
#(
    parameter int  DEPTH  = 784,
    parameter int  DATA_W = c_data_w,
    localparam int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Write port
    always_ff @(posedge clk) begin
        if (wen) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        r_rdata <= r_mem[raddr];
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_mac
//  Description : Single neuron: bias + sum(weight[i] * x[i]) over N_INPUTS
//                streamed samples, rescaled to the shared fixed-point format,
//                optionally saturated, then passed through the activation.
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_mac
    import nn_pkg::*;
#(
    parameter int        N_INPUTS = 784,
    parameter int        DATA_W   = c_data_w,
    parameter int        FRAC_W   = c_frac_w,
    parameter act_mode_t ACT      = RELU,
    parameter int        SATURATE = 1,
    localparam int       ADDR_W   = addr_w(N_INPUTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] bias,
    input  logic              w_wen,
    input  logic [ADDR_W-1:0] w_waddr,
    input  logic [DATA_W-1:0] w_wdata,
    input  logic [DATA_W-1:0] x_tdata,
    input  logic              x_tvalid,
    output logic              x_tready,
    output logic [DATA_W-1:0] a_tdata,
    output logic              a_tvalid,
    input  logic              a_tready,
    output logic              busy,
    output logic              ovf
);

    // Accumulator is wide enough that N_INPUTS full-scale products plus the
    // aligned bias can never overflow it.
    localparam int ACC_W = 2 * DATA_W + ADDR_W + 1;
    localparam int PRD_W = 2 * DATA_W;

    state_t                    r_state;
    logic [ADDR_W-1:0]         r_index;
    logic signed [DATA_W-1:0]  r_bias;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [PRD_W-1:0]   r_prod;
    logic                      r_prod_vld;
    logic                      r_drain_cnt;
    logic [DATA_W-1:0]         r_a_tdata;
    logic                      r_a_tvalid;
    logic                      r_ovf;

    logic                      w_hs;
    logic                      w_last;
    logic                      w_ram_wen;
    logic [ADDR_W-1:0]         w_rd_addr;
    logic [DATA_W-1:0]         w_weight;
    logic signed [ACC_W-1:0]   w_shift;
    logic                      w_fits;
    logic [DATA_W-1:0]         w_clamped;
    logic [DATA_W-1:0]         w_result;

    assign x_tready = (r_state == ACCUM);
    assign w_hs     = x_tready && x_tvalid;
    assign w_last   = (r_index == ADDR_W'(N_INPUTS - 1));

    // Writes are only accepted while idle, so an inference always sees a
    // stable weight set; a write coinciding with start lands before LOAD reads.
    assign w_ram_wen = w_wen && (r_state == IDLE);

    // Read address runs one index ahead so the weight for index i is on the
    // RAM output whenever r_index == i.
    always_comb begin
        w_rd_addr = r_index;
        if (r_state == LOAD) begin
            w_rd_addr = '0;
        end else if (w_hs && !w_last) begin
            w_rd_addr = r_index + 1'b1;
        end
    end

    weight_ram #(
        .DEPTH  (N_INPUTS),
        .DATA_W (DATA_W)
    ) u_weight_ram (
        .clk   (clk),
        .wen   (w_ram_wen),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .raddr (w_rd_addr),
        .rdata (w_weight)
    );

    // Rescale, range-limit and activate the final accumulator value
    always_comb begin
        w_shift   = r_acc >>> FRAC_W;
        // In range when every bit above the result sign bit matches it
        w_fits    = (&w_shift[ACC_W-1:DATA_W-1]) || (~|w_shift[ACC_W-1:DATA_W-1]);
        w_clamped = w_shift[DATA_W-1:0];
        if (!w_fits && (SATURATE != 0)) begin
            w_clamped = w_shift[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                         : {1'b0, {(DATA_W-1){1'b1}}};
        end
        w_result = w_clamped;
        if ((ACT == RELU) && w_clamped[DATA_W-1]) begin
            w_result = '0;
        end
    end

    // Sequencer, multiply stage and accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_index     <= '0;
            r_bias      <= '0;
            r_acc       <= '0;
            r_prod      <= '0;
            r_prod_vld  <= 1'b0;
            r_drain_cnt <= 1'b0;
            r_a_tdata   <= '0;
            r_a_tvalid  <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            // Product stage: registered on each accepted sample, added next cycle
            r_prod_vld <= w_hs;
            if (w_hs) begin
                r_prod <= PRD_W'($signed(w_weight)) * PRD_W'($signed(x_tdata));
            end
            if (r_prod_vld) begin
                r_acc <= r_acc + ACC_W'(r_prod);
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bias  <= $signed(bias);
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_acc   <= ACC_W'(r_bias) <<< FRAC_W;
                    r_index <= '0;
                    r_ovf   <= 1'b0;
                    r_state <= ACCUM;
                end
                ACCUM: begin
                    if (w_hs) begin
                        if (w_last) begin
                            r_drain_cnt <= 1'b0;
                            r_state     <= DRAIN;
                        end else begin
                            r_index <= r_index + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // First cycle performs the final add; second presents the result
                    if (!r_drain_cnt) begin
                        r_drain_cnt <= 1'b1;
                    end else begin
                        r_a_tdata  <= w_result;
                        r_a_tvalid <= 1'b1;
                        r_ovf      <= !w_fits;
                        r_state    <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (a_tready) begin
                        r_a_tvalid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign a_tdata  = r_a_tdata;
    assign a_tvalid = r_a_tvalid;
    assign ovf      = r_ovf;
    assign busy     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neuron_mac
//  Description : Directed self-checking bench for neuron_mac. Two instances
//                run in lock-step: dut_a (RELU, saturating) and dut_b (NONE,
//                wrapping). Expected results come from a behavioural model
//                and are queued per instance when an inference is launched.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_mac
    import nn_pkg::*;
;
    localparam int          N   = 4;
    localparam logic [31:0] ONE = 32'h0800_0000;

    typedef struct packed {
        logic [31:0] d;
        logic        o;
    } res_t;

    logic        clk = 1'b0;
    logic        rst, start, w_wen, x_tvalid, a_tready;
    logic [31:0] bias, w_wdata, x_tdata;
    logic [1:0]  w_waddr;
    logic        x_tready_a, a_tvalid_a, busy_a, ovf_a;
    logic        x_tready_b, a_tvalid_b, busy_b, ovf_b;
    logic [31:0] a_tdata_a, a_tdata_b;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          last_hs = 0;
    logic [31:0] mw [N];
    res_t        qa [$];
    res_t        qb [$];
    logic [31:0] obs_a, obs_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neuron_mac #(.N_INPUTS(N), .DATA_W(32), .FRAC_W(27), .ACT(RELU), .SATURATE(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .bias(bias),
        .w_wen(w_wen), .w_waddr(w_waddr), .w_wdata(w_wdata),
        .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(x_tready_a),
        .a_tdata(a_tdata_a), .a_tvalid(a_tvalid_a), .a_tready(a_tready),
        .busy(busy_a), .ovf(ovf_a)
    );

    neuron_mac #(.N_INPUTS(N), .DATA_W(32), .FRAC_W(27), .ACT(NONE), .SATURATE(0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .bias(bias),
        .w_wen(w_wen), .w_waddr(w_waddr), .w_wdata(w_wdata),
        .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(x_tready_b),
        .a_tdata(a_tdata_b), .a_tvalid(a_tvalid_b), .a_tready(a_tready),
        .busy(busy_b), .ovf(ovf_b)
    );

    // Behavioural reference: wide exact arithmetic, range check by comparison
    function automatic res_t model(input logic [31:0] b, input logic [31:0] x,
                                   input bit relu, input bit sat);
        logic signed [95:0] acc;
        logic signed [95:0] r;
        res_t t;
        acc = {{64{b[31]}}, b} <<< 27;
        for (int i = 0; i < N; i++) begin
            acc = acc + ({{64{mw[i][31]}}, mw[i]} * {{64{x[31]}}, x});
        end
        r   = acc >>> 27;
        t.o = (r > 96'sh7FFF_FFFF) || (r < -96'sh8000_0000);
        t.d = r[31:0];
        if (t.o && sat) t.d = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        if (relu && t.d[31]) t.d = 32'h0;
        return t;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_w(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        w_wen = 1'b1; w_waddr = addr; w_wdata = data;
        mw[addr] = data;
        @(negedge clk);
        w_wen = 1'b0;
    endtask

    // Launch one inference; optionally write a weight in the start cycle and
    // attempt a (to-be-ignored) write while busy.
    task automatic run(input logic [31:0] b, input logic [31:0] x, input bit toggle,
                       input bit inj_wr, input bit start_wr,
                       input logic [1:0] swa, input logic [31:0] swd);
        int sent = 0;
        @(negedge clk);
        start = 1'b1; bias = b;
        if (start_wr) begin
            w_wen = 1'b1; w_waddr = swa; w_wdata = swd;
            mw[swa] = swd;
        end
        qa.push_back(model(b, x, 1'b1, 1'b1));
        qb.push_back(model(b, x, 1'b0, 1'b0));
        @(negedge clk);
        start = 1'b0; w_wen = 1'b0; bias = 32'hDEAD_BEEF;
        for (int it = 0; it < 200 && sent < N; it++) begin
            x_tvalid = toggle ? it[0] : 1'b1;
            x_tdata  = x;
            if (inj_wr && it == 3) begin
                w_wen = 1'b1; w_waddr = 2'd1; w_wdata = 32'h0;
            end else begin
                w_wen = 1'b0;
            end
            if (x_tvalid && x_tready_a) begin
                sent++;
                last_hs = cyc;
            end
            @(negedge clk);
        end
        x_tvalid = 1'b0; w_wen = 1'b0;
        check("x_handshakes", sent, N);
    endtask

    // Wait for the result, check latency/value, optionally hold and poke start
    task automatic collect(input int hold, input bit pulse_start);
        res_t ea, eb;
        int   waited = 0;
        check("queue_depth", qa.size(), 1);
        ea = qa.pop_front();
        eb = qb.pop_front();
        while (!a_tvalid_a && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("a_tvalid_seen", a_tvalid_a, 1);
        check("a_tvalid_b", a_tvalid_b, 1);
        check("latency", cyc - last_hs, 3);
        check("data_a", a_tdata_a, ea.d);
        check("ovf_a", ovf_a, ea.o);
        check("data_b", a_tdata_b, eb.d);
        check("ovf_b", ovf_b, eb.o);
        obs_a = a_tdata_a;
        obs_b = a_tdata_b;
        for (int h = 0; h < hold; h++) begin
            a_tready = 1'b0;
            start    = (pulse_start && h == 2);
            @(negedge clk);
            start = 1'b0;
            check("hold_valid", a_tvalid_a, 1);
            check("hold_data", a_tdata_a, ea.d);
            check("hold_ovf", ovf_a, ea.o);
        end
        a_tready = 1'b1;
        @(negedge clk);
        a_tready = 1'b0;
        check("valid_drop", a_tvalid_a, 0);
        check("idle_a", busy_a, 0);
        check("idle_b", busy_b, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bias = '0; w_wen = 1'b0; w_waddr = '0;
        w_wdata = '0; x_tdata = '0; x_tvalid = 1'b0; a_tready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tready", x_tready_a, 0);
        check("rst_tvalid", a_tvalid_a, 0);
        check("rst_tdata", a_tdata_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_tvalid_b", a_tvalid_b, 0);
        rst = 1'b0;

        // 4 x (1.0 * 1.0); last weight written in the same cycle as start
        write_w(2'd0, ONE); write_w(2'd1, ONE); write_w(2'd2, ONE); write_w(2'd3, 32'h0);
        run(32'h0, ONE, 1'b0, 1'b0, 1'b1, 2'd3, ONE);
        collect(0, 1'b0);
        check("t1_spec_a", obs_a, 32'h2000_0000);

        // Zero weights, bias -1.0: RELU clips, NONE passes
        for (int i = 0; i < N; i++) write_w(2'(i), 32'h0);
        run(32'hF800_0000, ONE, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        collect(0, 1'b0);
        check("t2_spec_a", obs_a, 32'h0);
        check("t2_spec_b", obs_b, 32'hF800_0000);

        // 15.0 * 15.0 x 4 = 900: clamps (saturating) or wraps (wrapping)
        for (int i = 0; i < N; i++) write_w(2'(i), 32'h7800_0000);
        run(32'h0, 32'h7800_0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        collect(0, 1'b0);
        check("t3_spec_a", obs_a, 32'h7FFF_FFFF);
        check("t3_spec_b", obs_b, 32'h2000_0000);
        check("t3_ovf_held", ovf_b, 1);

        // Gapped input, long back-pressure, start during OUTPUT, write while busy
        for (int i = 0; i < N; i++) write_w(2'(i), ONE);
        run(32'h0, ONE, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0);
        collect(10, 1'b1);
        check("t4_spec_a", obs_a, 32'h2000_0000);
        repeat (3) begin
            @(negedge clk);
            check("no_restart", busy_a, 0);
        end
        run(32'h0, ONE, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        collect(0, 1'b0);
        check("ram_unchanged", obs_a, 32'h2000_0000);

        // Reset after the second handshake aborts the run silently
        @(negedge clk);
        start = 1'b1; bias = 32'h0;
        @(negedge clk);
        start = 1'b0; x_tvalid = 1'b1; x_tdata = ONE;
        repeat (3) @(negedge clk);
        x_tvalid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("abort_no_valid", a_tvalid_a, 0);
            @(negedge clk);
        end
        check("abort_idle", busy_a, 0);
        run(32'h0, ONE, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        collect(0, 1'b0);
        check("t5_spec_a", obs_a, 32'h2000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
